// File: rtl/neo_pkg.sv
// Shared constants and types for the NeoPixel pattern sequencer.
package neo_pkg;

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] BLUE  = 2'b01;
  localparam logic [1:0] GREEN = 2'b10;

  localparam int unsigned NUM_PIXELS_DEFAULT = 5;
  localparam int unsigned TIMER_W            = 22;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    BUSY,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/neo_pattern_sequencer_counter.sv
// Generic up-counter: clear presets q to d, otherwise en increments q.
module neo_pattern_sequencer_counter #(
  parameter int unsigned WIDTH = 22
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= d;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/neo_pattern_sequencer.sv
// Single-pixel chase: loads one frame of R/B/G levels into a strand controller,
// triggers a send, waits out the frame period, then advances the lit pixel.
module neo_pattern_sequencer
  import neo_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int unsigned FRAME_WAIT = 2500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        reverse,
  input  logic [23:0] base_color,
  input  logic        ready_to_load,
  input  logic        ready_to_send,
  output logic        load_color,
  output logic [1:0]  color_index,
  output logic [2:0]  pixel_index,
  output logic [7:0]  color_level,
  output logic        send_it,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0]         LAST_PIXEL = 3'(NUM_PIXELS - 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST  = TIMER_W'(FRAME_WAIT - 1);

  seq_state_t         state;
  seq_state_t         next_state;
  logic [23:0]        color_latch;
  logic               seen_low;
  logic [TIMER_W-1:0] timer_q;
  logic               timer_clear;
  logic               timer_en;
  logic               frame_end;
  logic               last_load;

  assign last_load = (pixel_index == LAST_PIXEL) && (color_index == GREEN);

  // Timer saturates so a stuck downstream cannot wrap it back below the limit.
  assign timer_en = ((state == BUSY) || (state == HOLD)) && (timer_q != '1);

  neo_pattern_sequencer_counter #(
    .WIDTH(TIMER_W)
  ) u_frame_timer (
    .clock(clock),
    .reset(reset),
    .en   (timer_en),
    .clear(timer_clear),
    .d    (TIMER_W'(0)),
    .q    (timer_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    load_color  = 1'b0;
    send_it     = 1'b0;
    timer_clear = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = LOAD;
      end
      LOAD: begin
        if (ready_to_load) begin
          load_color = 1'b1;
          if (last_load) next_state = SEND;
        end
      end
      SEND: begin
        if (ready_to_send) begin
          send_it     = 1'b1;
          timer_clear = 1'b1;
          next_state  = BUSY;
        end
      end
      BUSY: begin
        if (seen_low && ready_to_send) next_state = HOLD;
      end
      HOLD: begin
        if (timer_q >= WAIT_LAST) begin
          frame_end  = 1'b1;
          next_state = enable ? LOAD : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      color_latch <= '0;
      pixel_index <= '0;
      color_index <= RED;
      phase       <= '0;
      seen_low    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      frame_done <= frame_end;

      if ((state == IDLE) && enable) begin
        color_latch <= base_color;
        pixel_index <= '0;
        color_index <= RED;
      end

      // Walk R -> B -> G within a pixel, then step to the next pixel.
      if (load_color) begin
        if (color_index == GREEN) begin
          color_index <= RED;
          pixel_index <= last_load ? 3'd0 : pixel_index + 3'd1;
        end else begin
          color_index <= color_index + 2'd1;
        end
      end

      if (send_it) begin
        seen_low <= 1'b0;
      end else if ((state == BUSY) && !ready_to_send) begin
        seen_low <= 1'b1;
      end

      if (frame_end) begin
        color_latch <= base_color;
        if (reverse) begin
          phase <= (phase == 3'd0) ? LAST_PIXEL : phase - 3'd1;
        end else begin
          phase <= (phase == LAST_PIXEL) ? 3'd0 : phase + 3'd1;
        end
      end
    end
  end

  // Only the lit pixel carries the latched colour; all others are dark.
  always_comb begin
    color_level = 8'd0;
    if (pixel_index == phase) begin
      case (color_index)
        RED:     color_level = color_latch[15:8];
        BLUE:    color_level = color_latch[7:0];
        GREEN:   color_level = color_latch[23:16];
        default: color_level = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// Scoreboard bench for neo_pattern_sequencer: directed frames push expected
// loads/sends/phases; a negedge monitor pops and compares on each strobe.
module tb_neo_pattern_sequencer;

  localparam int unsigned NP = 5;
  localparam int unsigned FW = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        reverse = 1'b0;
  logic [23:0] base_color = '0;
  logic        ready_to_load = 1'b0;
  logic        ready_to_send = 1'b0;
  logic        load_color;
  logic [1:0]  color_index;
  logic [2:0]  pixel_index;
  logic [7:0]  color_level;
  logic        send_it;
  logic [2:0]  phase;
  logic        busy;
  logic        frame_done;

  neo_pattern_sequencer #(
    .NUM_PIXELS(NP),
    .FRAME_WAIT(FW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .reverse      (reverse),
    .base_color   (base_color),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send),
    .load_color   (load_color),
    .color_index  (color_index),
    .pixel_index  (pixel_index),
    .color_level  (color_level),
    .send_it      (send_it),
    .phase        (phase),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       kind;  // 0 = load, 1 = send
    logic [2:0] pix;
    logic [1:0] cidx;
    logic [7:0] lvl;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] phase_q[$];
  int         load_cycles[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int loads_seen = 0;
  int sends_seen = 0;
  int frames_seen = 0;
  int send_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lvl_of(input logic [23:0] col, input int c, input int p, input int ph);
    if (p != ph) return 8'd0;
    case (c)
      0:       return col[15:8];
      1:       return col[7:0];
      default: return col[23:16];
    endcase
  endfunction

  // Monitor: compare every strobe against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (load_color && send_it) begin
        compared++;
        mismatched++;
        $display("FAIL strobe_overlap: load_color and send_it both high (cycle %0d)", cyc);
      end
      if (load_color) begin
        if (exp_q.size() == 0 || exp_q[0].kind) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_load: pix %0d col %0d lvl 0x%0h (cycle %0d)",
                   pixel_index, color_index, color_level, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("load", int'({pixel_index, color_index, color_level}), int'({e.pix, e.cidx, e.lvl}));
        end
        loads_seen++;
        load_cycles.push_back(cyc);
      end else if (send_it) begin
        compared++;
        if (exp_q.size() == 0 || !exp_q[0].kind) begin
          mismatched++;
          $display("FAIL unexpected_send: got send_it, want %0d more loads (cycle %0d)", exp_q.size(), cyc);
        end else begin
          void'(exp_q.pop_front());
        end
        sends_seen++;
        send_cyc = cyc;
      end
      if (frame_done) begin
        if (phase_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame_done: phase %0d (cycle %0d)", phase, cyc);
        end else begin
          check("phase", int'(phase), int'(phase_q.pop_front()));
        end
        check("frame_spacing_ge_wait", int'((cyc - send_cyc) >= int'(FW)), 1);
        frames_seen++;
      end
    end
  end

  task automatic run_frame(input int ph, input logic [23:0] col, input logic [23:0] col_next,
                           input logic rev, input int stall_at, input bit drop_en, input bit abort);
    int  start, s0, f0, nph, n;
    bit  stalled, changed, dropped;
    stalled = 0;
    changed = 0;
    dropped = 0;
    nph = rev ? ((ph == 0) ? int'(NP) - 1 : ph - 1) : ((ph == int'(NP) - 1) ? 0 : ph + 1);
    for (int p = 0; p < int'(NP); p++) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back('{kind: 1'b0, pix: 3'(p), cidx: 2'(c), lvl: lvl_of(col, c, p, ph)});
      end
    end
    exp_q.push_back('{kind: 1'b1, pix: 3'd0, cidx: 2'd0, lvl: 8'd0});
    if (!abort) phase_q.push_back(3'(nph));
    load_cycles.delete();
    start = loads_seen;
    s0 = sends_seen;
    f0 = frames_seen;
    base_color = col;
    reverse = rev;
    ready_to_send = 1'b1;
    ready_to_load = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 300 && (loads_seen - start) < 15; i++) begin
      @(posedge clock); #1;
      n = loads_seen - start;
      if (!changed && n >= 6) begin
        base_color = col_next;
        changed = 1;
      end
      if (drop_en && !dropped && n == 4) begin
        enable = 1'b0;
        dropped = 1;
      end
      if (stall_at > 0 && !stalled && n == stall_at) begin
        ready_to_load = 1'b0;
        stalled = 1;
        for (int j = 0; j < 7; j++) begin
          @(negedge clock);
          check("stall_no_load", int'(load_color), 0);
          check("stall_pixel", int'(pixel_index), stall_at / 3);
          check("stall_color", int'(color_index), stall_at % 3);
          @(posedge clock); #1;
        end
        ready_to_load = 1'b1;
      end
    end
    check("load_count", loads_seen - start, 15);
    ready_to_load = 1'b0;
    if (load_cycles.size() == 15) begin
      check("load_span", load_cycles[14] - load_cycles[0], (stall_at > 0) ? 21 : 14);
    end

    for (int i = 0; i < 50 && sends_seen == s0; i++) begin
      @(posedge clock); #1;
    end
    check("send_count", sends_seen - s0, 1);
    ready_to_send = 1'b0;

    if (abort) begin
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("reset_mid_outputs",
            int'({load_color, send_it, busy, frame_done, phase, pixel_index, color_index, color_level}), 0);
      base_color = col_next;
      phase_q.delete();
      check("scoreboard_drained", exp_q.size(), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      ready_to_send = 1'b1;
      return;
    end

    repeat (3) begin
      @(posedge clock); #1;
    end
    ready_to_send = 1'b1;
    for (int i = 0; i < 400 && frames_seen == f0; i++) begin
      @(posedge clock); #1;
    end
    check("frame_done_count", frames_seen - f0, 1);

    if (drop_en) begin
      repeat (3) begin
        @(posedge clock); #1;
      end
      @(negedge clock);
      check("idle_busy", int'(busy), 0);
      check("idle_no_load", int'(load_color), 0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state",
          int'({load_color, send_it, busy, frame_done, phase, pixel_index, color_index, color_level}), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_without_enable", int'(busy), 0);

    // Forward chase 0,1,2,3,4,0; the sixth frame advances in reverse.
    run_frame(0, 24'h10_20_30, 24'h10_20_30, 1'b0, 0, 0, 0);
    run_frame(1, 24'h10_20_30, 24'h10_20_30, 1'b0, 7, 0, 0);
    run_frame(2, 24'h10_20_30, 24'hAA_BB_CC, 1'b0, 0, 0, 0);
    run_frame(3, 24'hAA_BB_CC, 24'hAA_BB_CC, 1'b0, 0, 0, 0);
    run_frame(4, 24'hAA_BB_CC, 24'hAA_BB_CC, 1'b0, 0, 0, 0);
    run_frame(0, 24'hAA_BB_CC, 24'hAA_BB_CC, 1'b1, 0, 0, 0);
    run_frame(4, 24'hAA_BB_CC, 24'hAA_BB_CC, 1'b1, 0, 1, 0);
    run_frame(3, 24'h11_22_33, 24'h44_55_66, 1'b0, 0, 0, 1);
    run_frame(0, 24'h44_55_66, 24'h44_55_66, 1'b0, 0, 0, 0);

    repeat (5) @(posedge clock);
    #1;
    check("final_exp_queue", exp_q.size(), 0);
    check("final_phase_queue", phase_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
